// File: rtl/riscv_pkg.sv
// Opcode constants and shared types for the RV64IM decode/issue stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    OC_NONE, OC_ALU, OC_MULDIV, OC_LOAD, OC_STORE, OC_BRANCH,
    OC_JAL, OC_JALR, OC_LUI, OC_AUIPC, OC_FENCE, OC_SYS
  } opclass_e;

  typedef enum logic {RUN, DRAIN} state_e;

  function automatic logic is_serial(opclass_e c);
    return (c == OC_FENCE) || (c == OC_SYS);
  endfunction

endpackage

// File: rtl/opclass_decode.sv
// Combinational RV64IM + Zicsr + Zifencei classifier: op class, legality
// and which source registers the instruction reads.
module opclass_decode
  import riscv_pkg::*;
(
  input  logic [31:0] ir_i,
  output opclass_e    class_o,
  output logic        illegal_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  opclass_e   cls;
  logic       legal;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign funct7 = ir_i[31:25];

  always_comb begin
    cls   = OC_NONE;
    legal = 1'b0;
    case (opcode)
      OPC_LOAD:   begin cls = OC_LOAD;   legal = (funct3 != 3'b111);     end
      OPC_STORE:  begin cls = OC_STORE;  legal = !funct3[2];             end
      OPC_BRANCH: begin cls = OC_BRANCH; legal = (funct3[2:1] != 2'b01); end
      OPC_JALR:   begin cls = OC_JALR;   legal = (funct3 == 3'b000);     end
      OPC_JAL:    begin cls = OC_JAL;    legal = 1'b1;                   end
      OPC_LUI:    begin cls = OC_LUI;    legal = 1'b1;                   end
      OPC_AUIPC:  begin cls = OC_AUIPC;  legal = 1'b1;                   end
      OPC_OP_IMM: begin
        // RV64 shift-immediates carry a 6-bit shamt, so only ir[31:26] is funct
        cls = OC_ALU;
        case (funct3)
          3'b001:  legal = (ir_i[31:26] == 6'b000000);
          3'b101:  legal = (ir_i[31:26] == 6'b000000) || (ir_i[31:26] == 6'b010000);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP_IMM_32: begin
        cls = OC_ALU;
        case (funct3)
          3'b000:  legal = 1'b1;
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        cls = (funct7 == F7_MULDIV) ? OC_MULDIV : OC_ALU;
        case (funct7)
          F7_BASE:   legal = 1'b1;
          F7_ALT:    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
          F7_MULDIV: legal = 1'b1;
          default:   legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        cls = (funct7 == F7_MULDIV) ? OC_MULDIV : OC_ALU;
        case (funct7)
          F7_BASE:   legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101);
          F7_ALT:    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
          F7_MULDIV: legal = (funct3 == 3'b000) || funct3[2];
          default:   legal = 1'b0;
        endcase
      end
      OPC_MISC_MEM: begin cls = OC_FENCE; legal = (funct3[2:1] == 2'b00); end
      OPC_SYSTEM: begin
        // funct3=0 is only ecall/ebreak; privileged returns are outside this ISA subset
        cls = OC_SYS;
        if (funct3 == 3'b000)
          legal = (ir_i[31:7] == 25'h0) || (ir_i[31:7] == 25'h0002000);
        else
          legal = (funct3 != 3'b100);
      end
      default: ;
    endcase
  end

  assign class_o    = legal ? cls : OC_NONE;
  assign illegal_o  = !legal;
  assign uses_rs1_o = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign uses_rs2_o = (opcode == OPC_OP) || (opcode == OPC_OP_32) ||
                      (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode stage sequencer: 2-entry instruction queue, load-use stall,
// serialization of fence/system ops until execute drains, and flush.
module decode_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int PC_W  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid,
  input  logic [31:0]     if_ir,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_ir,
  output logic [PC_W-1:0] id_pc,
  output opclass_e        id_class,
  output logic            id_illegal,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  input  logic            ex_idle,
  input  logic            flush,
  output logic            hazard_stall
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [31:0]     ir_q [DEPTH];
  logic [PC_W-1:0] pc_q [DEPTH];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q, count_d;
  logic            rdy_en_q;
  state_e          state_q;
  logic            drain_armed_q;

  logic [31:0]     head_ir;
  logic [PC_W-1:0] head_pc;
  opclass_e        head_class;
  logic            head_illegal, head_rs1, head_rs2;
  logic            not_empty, hazard, serial, push, pop;

  assign head_ir   = ir_q[rd_ptr_q];
  assign head_pc   = pc_q[rd_ptr_q];
  assign not_empty = (count_q != 2'd0);

  opclass_decode u_decode (
    .ir_i       (head_ir),
    .class_o    (head_class),
    .illegal_o  (head_illegal),
    .uses_rs1_o (head_rs1),
    .uses_rs2_o (head_rs2)
  );

  assign hazard = not_empty && ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((head_rs1 && (ex_load_rd == head_ir[19:15])) ||
                   (head_rs2 && (ex_load_rd == head_ir[24:20])));
  assign serial = is_serial(head_class);

  assign id_valid     = not_empty && !hazard && !(serial && !ex_idle);
  assign hazard_stall = hazard;
  assign if_ready     = rdy_en_q && (count_q < FULL) && (state_q == RUN) && !flush;
  assign push         = if_valid && if_ready;
  assign pop          = id_valid && id_ready;

  // Stale entries stay in storage after a pop; present zeros when empty
  assign id_ir      = not_empty ? head_ir : 32'd0;
  assign id_pc      = not_empty ? head_pc : '0;
  assign id_class   = not_empty ? head_class : OC_NONE;
  assign id_illegal = not_empty && head_illegal;

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = 2'd0;
    else if (push && !pop)
      count_d = count_q + 2'd1;
    else if (pop && !push)
      count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i] <= 32'd0;
        pc_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      count_q  <= count_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          ir_q[wr_ptr_q] <= if_ir;
          pc_q[wr_ptr_q] <= if_pc;
          wr_ptr_q       <= !wr_ptr_q;
        end
        if (pop)
          rd_ptr_q <= !rd_ptr_q;
      end
    end
  end

  // DRAIN ignores ex_idle on its first cycle: execute has not yet seen the serializing op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      drain_armed_q <= 1'b0;
    end else if (flush) begin
      state_q       <= RUN;
      drain_armed_q <= 1'b0;
    end else if (pop && serial) begin
      state_q       <= DRAIN;
      drain_armed_q <= 1'b0;
    end else if (state_q == DRAIN) begin
      if (!drain_armed_q)
        drain_armed_q <= 1'b1;
      else if (ex_idle)
        state_q <= RUN;
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: directed sequences, a class table
// and randomized traffic against a queue-based reference model.
module tb_decode_issue_ctrl;
  import riscv_pkg::*;

  logic        clk, reset_n;
  logic        if_valid, if_ready, id_valid, id_ready;
  logic [31:0] if_ir, id_ir;
  logic [63:0] if_pc, id_pc;
  opclass_e    id_class;
  logic        id_illegal, ex_load_valid, ex_idle, flush, hazard_stall;
  logic [4:0]  ex_load_rd;

  decode_issue_ctrl #(.PC_W(64), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc), .if_ready(if_ready),
    .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_pc(id_pc),
    .id_class(id_class), .id_illegal(id_illegal),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .ex_idle(ex_idle),
    .flush(flush), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] ir;
    opclass_e    cls;
    logic        ill;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] ir, input opclass_e c, input logic il);
    vec_t v;
    v.ir = ir; v.cls = c; v.ill = il;
    vecs.push_back(v);
  endtask

  // Reference model: instruction queue plus drain bookkeeping
  logic [31:0] qir[$];
  logic [63:0] qpc[$];
  opclass_e    qcls[$];
  logic        qill[$];
  bit          m_drain, m_aged;

  function automatic logic m_uses_rs1(logic [31:0] w);
    return !(w[6:0] == OPC_LUI || w[6:0] == OPC_AUIPC || w[6:0] == OPC_JAL);
  endfunction

  function automatic logic m_uses_rs2(logic [31:0] w);
    return w[6:0] == OPC_OP || w[6:0] == OPC_OP_32 || w[6:0] == OPC_STORE || w[6:0] == OPC_BRANCH;
  endfunction

  localparam logic [31:0] W1 = 32'h00100093;
  localparam logic [31:0] W2 = 32'h00200113;
  localparam logic [31:0] W3 = 32'h00300193;

  logic [31:0] w;
  int          k;
  bit          e_rdy, e_val, e_haz, e_push, e_pop, e_ser;
  logic [31:0] e_ir;
  logic [63:0] e_pc;
  opclass_e    e_cls;
  logic        e_ill;

  initial begin
    add_vec(32'h00500093, OC_ALU,    1'b0);
    add_vec(32'h002081b3, OC_ALU,    1'b0);
    add_vec(32'h0220c1b3, OC_MULDIV, 1'b0);
    add_vec(32'h042081b3, OC_NONE,   1'b1);
    add_vec(32'h00012083, OC_LOAD,   1'b0);
    add_vec(32'h00017083, OC_NONE,   1'b1);
    add_vec(32'h00112023, OC_STORE,  1'b0);
    add_vec(32'h00208063, OC_BRANCH, 1'b0);
    add_vec(32'h0020a063, OC_NONE,   1'b1);
    add_vec(32'h123450b7, OC_LUI,    1'b0);
    add_vec(32'h00000097, OC_AUIPC,  1'b0);
    add_vec(32'h008000ef, OC_JAL,    1'b0);
    add_vec(32'h00008067, OC_JALR,   1'b0);
    add_vec(32'h00009067, OC_NONE,   1'b1);
    add_vec(32'h0000100f, OC_FENCE,  1'b0);
    add_vec(32'h0ff0000f, OC_FENCE,  1'b0);
    add_vec(32'h00000073, OC_SYS,    1'b0);
    add_vec(32'h00100073, OC_SYS,    1'b0);
    add_vec(32'h30001073, OC_SYS,    1'b0);
    add_vec(32'h00004073, OC_NONE,   1'b1);
    add_vec(32'h022081bb, OC_MULDIV, 1'b0);
    add_vec(32'h022091bb, OC_NONE,   1'b1);
    add_vec(32'h0010809b, OC_ALU,    1'b0);
    add_vec(32'h402081b3, OC_ALU,    1'b0);
    add_vec(32'h4020d1b3, OC_ALU,    1'b0);
    add_vec(32'h402091b3, OC_NONE,   1'b1);
    add_vec(32'h00000000, OC_NONE,   1'b1);

    // Reset values
    reset_n = 1'b0; if_valid = 1'b0; if_ir = '0; if_pc = '0; id_ready = 1'b0;
    ex_load_valid = 1'b0; ex_load_rd = '0; ex_idle = 1'b1; flush = 1'b0;
    #1;
    chk("rst_if_ready", if_ready, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_ir", id_ir, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_class", id_class, OC_NONE);
    chk("rst_id_illegal", id_illegal, 0);
    chk("rst_hazard", hazard_stall, 0);
    step(); step();
    chk("rst_if_ready_clocked", if_ready, 0);
    reset_n = 1'b1;
    @(negedge clk) chk("rel_if_ready_before_clk", if_ready, 0);
    step();
    @(negedge clk) chk("rel_if_ready_after_clk", if_ready, 1);

    // Back-to-back traffic
    step(); if_valid = 1; if_ir = 32'h00500093; if_pc = 64'h100; id_ready = 1;
    @(negedge clk) chk("b2b_empty_valid", id_valid, 0);
    step(); if_ir = 32'h002081b3; if_pc = 64'h104;
    @(negedge clk);
    chk("b2b_first_valid", id_valid, 1);
    chk("b2b_first_ir", id_ir, 32'h00500093);
    chk("b2b_first_class", id_class, OC_ALU);
    chk("b2b_if_ready", if_ready, 1);
    step(); if_valid = 0;
    @(negedge clk);
    chk("b2b_second_ir", id_ir, 32'h002081b3);
    chk("b2b_second_pc", id_pc, 64'h104);
    chk("b2b_second_class", id_class, OC_ALU);
    step(); id_ready = 0;
    @(negedge clk) chk("b2b_drained", id_valid, 0);

    // Backpressure
    step(); if_valid = 1; if_ir = W1; if_pc = 64'h200;
    step(); if_ir = W2; if_pc = 64'h204;
    @(negedge clk) chk("bp_head_w1", id_ir, W1);
    step(); if_ir = W3; if_pc = 64'h208;
    @(negedge clk) chk("bp_full_if_ready", if_ready, 0);
    step(); id_ready = 1;
    @(negedge clk);
    chk("bp_pop1_ir", id_ir, W1);
    chk("bp_pop1_if_ready", if_ready, 0);
    step();
    @(negedge clk);
    chk("bp_pop2_ir", id_ir, W2);
    chk("bp_pop2_if_ready", if_ready, 1);
    step(); if_valid = 0;
    @(negedge clk);
    chk("bp_third_ir", id_ir, W3);
    chk("bp_third_pc", id_pc, 64'h208);
    step(); id_ready = 0;
    @(negedge clk) chk("bp_empty", id_valid, 0);

    // Load-use hazard on add x3,x1,x2
    step(); if_valid = 1; if_ir = 32'h002081b3; if_pc = 64'h300;
    step(); if_valid = 0; ex_load_valid = 1; ex_load_rd = 5'd2;
    @(negedge clk);
    chk("lu_rd2_stall", hazard_stall, 1);
    chk("lu_rd2_valid", id_valid, 0);
    step(); ex_load_rd = 5'd0;
    @(negedge clk);
    chk("lu_rd0_stall", hazard_stall, 0);
    chk("lu_rd0_valid", id_valid, 1);
    step(); ex_load_rd = 5'd5;
    @(negedge clk) chk("lu_rd5_valid", id_valid, 1);
    step(); ex_load_rd = 5'd1;
    @(negedge clk) chk("lu_rd1_stall", hazard_stall, 1);
    step(); ex_load_valid = 0; id_ready = 1;
    @(negedge clk) chk("lu_clear_valid", id_valid, 1);
    step(); id_ready = 0;

    // Serialization of fence.i
    step(); ex_idle = 0; if_valid = 1; if_ir = 32'h0000100f; if_pc = 64'h400;
    step(); if_valid = 0; id_ready = 1;
    @(negedge clk);
    chk("ser_busy_valid", id_valid, 0);
    chk("ser_class", id_class, OC_FENCE);
    chk("ser_busy_stall", hazard_stall, 0);
    step(); ex_idle = 1;
    @(negedge clk) chk("ser_idle_valid", id_valid, 1);
    step(); id_ready = 0;
    @(negedge clk) chk("ser_drain_entry_rdy", if_ready, 0);
    step(); ex_idle = 0;
    @(negedge clk) chk("ser_drain_busy_rdy", if_ready, 0);
    step(); ex_idle = 1;
    @(negedge clk) chk("ser_drain_idle_rdy", if_ready, 0);
    step();
    @(negedge clk) chk("ser_back_to_run", if_ready, 1);

    // Flush at count==2 with a word offered in the flush cycle
    step(); if_valid = 1; if_ir = W1; if_pc = 64'h500;
    step(); if_ir = W2; if_pc = 64'h504;
    step(); flush = 1; if_ir = 32'h00000013; if_pc = 64'h999;
    @(negedge clk);
    chk("fl_if_ready", if_ready, 0);
    chk("fl_head_valid", id_valid, 1);
    step(); flush = 0; if_ir = W3; if_pc = 64'h600;
    @(negedge clk);
    chk("fl_after_valid", id_valid, 0);
    chk("fl_after_if_ready", if_ready, 1);
    step(); if_valid = 0;
    @(negedge clk);
    chk("fl_new_head_ir", id_ir, W3);
    chk("fl_new_head_pc", id_pc, 64'h600);
    step(); id_ready = 1;
    step(); id_ready = 0; if_valid = 1; if_ir = 32'h00000073; if_pc = 64'h700;
    step(); if_valid = 0; id_ready = 1;
    @(negedge clk) chk("fl_ecall_valid", id_valid, 1);
    step(); id_ready = 0; ex_idle = 0; flush = 1;
    @(negedge clk) chk("fl_drain_rdy", if_ready, 0);
    step(); flush = 0;
    @(negedge clk) chk("fl_drain_to_run", if_ready, 1);
    ex_idle = 1;

    // Reset asserted mid-stream
    step(); if_valid = 1; if_ir = W1; if_pc = 64'h800;
    step(); if_ir = W2;
    step(); if_valid = 0;
    @(negedge clk) chk("mr_valid_before", id_valid, 1);
    #2 reset_n = 0;
    #1;
    chk("mr_id_valid", id_valid, 0);
    chk("mr_if_ready", if_ready, 0);
    chk("mr_id_ir", id_ir, 0);
    chk("mr_id_class", id_class, OC_NONE);
    chk("mr_hazard", hazard_stall, 0);
    step(); reset_n = 1;

    // Class table: each word pushed alone and issued once
    for (int i = 0; i < vecs.size(); i++) begin
      step(); if_valid = 1; if_ir = vecs[i].ir; if_pc = 64'h1000 + 64'(i * 4); id_ready = 0;
      step(); if_valid = 0; id_ready = 1;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), id_valid, 1);
      chk($sformatf("tbl%0d_ir", i), id_ir, vecs[i].ir);
      chk($sformatf("tbl%0d_pc", i), id_pc, 64'h1000 + 64'(i * 4));
      chk($sformatf("tbl%0d_class", i), id_class, vecs[i].cls);
      chk($sformatf("tbl%0d_illegal", i), id_illegal, vecs[i].ill);
      step(); id_ready = 0;
      repeat (3) @(posedge clk);
    end

    // Randomized traffic against the reference model
    reset_n = 0;
    step(); reset_n = 1;
    qir.delete(); qpc.delete(); qcls.delete(); qill.delete();
    m_drain = 0; m_aged = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      k = $urandom_range(0, vecs.size() - 1);
      w = vecs[k].ir;
      if (w[6:0] != OPC_SYSTEM) begin
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
      end
      if_valid      = ($urandom_range(0, 3) != 0);
      if_ir         = w;
      if_pc         = {$urandom, $urandom};
      id_ready      = ($urandom_range(0, 2) != 0);
      ex_load_valid = ($urandom_range(0, 2) == 0);
      ex_load_rd    = 5'($urandom_range(0, 3));
      ex_idle       = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      @(negedge clk);

      e_rdy = (qir.size() < 2) && !m_drain && !flush;
      if (qir.size() > 0) begin
        e_ir  = qir[0]; e_pc = qpc[0]; e_cls = qcls[0]; e_ill = qill[0];
        e_haz = ex_load_valid && (ex_load_rd != 0) &&
                ((m_uses_rs1(e_ir) && ex_load_rd == e_ir[19:15]) ||
                 (m_uses_rs2(e_ir) && ex_load_rd == e_ir[24:20]));
        e_ser = (e_cls == OC_FENCE) || (e_cls == OC_SYS);
        e_val = !e_haz && !(e_ser && !ex_idle);
      end else begin
        e_ir = 0; e_pc = 0; e_cls = OC_NONE; e_ill = 0; e_haz = 0; e_ser = 0; e_val = 0;
      end
      chk("rnd_if_ready", if_ready, e_rdy);
      chk("rnd_id_valid", id_valid, e_val);
      chk("rnd_hazard", hazard_stall, e_haz);
      chk("rnd_id_ir", id_ir, e_ir);
      chk("rnd_id_pc", id_pc, e_pc);
      chk("rnd_id_class", id_class, e_cls);
      chk("rnd_id_illegal", id_illegal, e_ill);

      e_push = if_valid && e_rdy;
      e_pop  = e_val && id_ready;
      if (flush) begin
        qir.delete(); qpc.delete(); qcls.delete(); qill.delete();
        m_drain = 0; m_aged = 0;
      end else begin
        if (e_pop) begin
          void'(qir.pop_front()); void'(qpc.pop_front());
          void'(qcls.pop_front()); void'(qill.pop_front());
        end
        if (e_pop && e_ser) begin
          m_drain = 1; m_aged = 0;
        end else if (m_drain) begin
          if (!m_aged) m_aged = 1;
          else if (ex_idle) m_drain = 0;
        end
        if (e_push) begin
          qir.push_back(if_ir); qpc.push_back(if_pc);
          qcls.push_back(vecs[k].cls); qill.push_back(vecs[k].ill);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
